// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        HI,
        LO,
        WRITE,
        CHECK,
        DONE,
        ERR
    } loader_state_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input, program-memory write port and CPU status flags of the loader.
// The slave modport is the loader side; the master modport is the byte source / observer.
interface prog_loader_if #(
    parameter int AW = 8,
    parameter int DW = 13
);
    logic [7:0]    inData;
    logic          inValid;
    logic          inReady;
    logic          pmWrEn;
    logic [AW-1:0] pmWrAddr;
    logic [DW-1:0] pmWrData;
    logic          cpuHold;
    logic          done;
    logic          error;

    modport master (
        output inData, inValid,
        input  inReady, pmWrEn, pmWrAddr, pmWrData, cpuHold, done, error
    );

    modport slave (
        input  inData, inValid,
        output inReady, pmWrEn, pmWrAddr, pmWrData, cpuHold, done, error
    );
endinterface

// File: rtl/prog_loader_byte_timeout.sv
// Inter-byte idle watchdog: counts cycles while run is high, restarts on clear,
// and flags expiry once the count reaches TIMEOUT.
module byte_timeout #(
    parameter int TIMEOUT = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expired
);
    localparam int             CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = run && (cnt_q == LIMIT);

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses HEADER/N/{HI,LO}*(N+1)/CK frames from a byte stream,
// writes each assembled word into program memory and releases the CPU only
// after a frame with a good checksum.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         prog_mem_length = 8,
    parameter int         prog_mem_width  = 13,
    parameter logic [7:0] HEADER          = HEADER_DEFAULT,
    parameter int         TIMEOUT         = 65535
) (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus
);
    localparam int         L        = prog_mem_length;
    localparam int         W        = prog_mem_width;
    localparam logic [8:0] MAX_ADDR = 9'((1 << L) - 1);

    loader_state_t state_q, state_d;
    logic [L-1:0]  addr_q,  addr_d;
    logic [7:0]    n_q,     n_d;
    logic [7:0]    sum_q,   sum_d;
    logic [W-9:0]  hi_q,    hi_d;
    logic [W-1:0]  data_q,  data_d;
    logic          hold_q,  hold_d;
    logic          done_q,  done_d;
    logic          error_q, error_d;

    logic accept;
    logic timer_run;
    logic timer_clear;
    logic timed_out;
    logic go_err;

    assign accept      = bus.inValid && (state_q != WRITE);
    assign timer_run   = (state_q == COUNT) || (state_q == HI) ||
                         (state_q == LO)    || (state_q == CHECK);
    assign timer_clear = accept || !timer_run;

    byte_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .run     (timer_run),
        .clear   (timer_clear),
        .expired (timed_out)
    );

    // Frame parser: next state, address/checksum/word datapath and status flags.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        n_d     = n_q;
        sum_d   = sum_q;
        hi_d    = hi_q;
        data_d  = data_q;
        hold_d  = hold_q;
        done_d  = done_q;
        error_d = error_q;
        go_err  = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                // Only a header is meaningful outside a frame; everything else is dropped.
                if (accept && (bus.inData == HEADER)) begin
                    state_d = COUNT;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end
            end
            COUNT: begin
                if (timed_out) begin
                    go_err = 1'b1;
                end else if (accept) begin
                    n_d    = bus.inData;
                    sum_d  = bus.inData;
                    addr_d = '0;
                    if ({1'b0, bus.inData} > MAX_ADDR) begin
                        go_err = 1'b1;
                    end else begin
                        state_d = HI;
                    end
                end
            end
            HI: begin
                if (timed_out) begin
                    go_err = 1'b1;
                end else if (accept) begin
                    hi_d    = bus.inData[W-9:0];
                    sum_d   = sum_q + bus.inData;
                    state_d = LO;
                end
            end
            LO: begin
                if (timed_out) begin
                    go_err = 1'b1;
                end else if (accept) begin
                    sum_d   = sum_q + bus.inData;
                    data_d  = {hi_q, bus.inData};
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (8'(addr_q) == n_q) begin
                    state_d = CHECK;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = HI;
                end
            end
            CHECK: begin
                if (timed_out) begin
                    go_err = 1'b1;
                end else if (accept) begin
                    if (8'(sum_q + bus.inData) == 8'h00) begin
                        state_d = DONE;
                        hold_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        go_err = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (go_err) begin
            state_d = ERR;
            error_d = 1'b1;
            hold_d  = 1'b1;
            done_d  = 1'b0;
        end
    end

    // State, datapath and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            n_q     <= '0;
            sum_q   <= '0;
            hi_q    <= '0;
            data_q  <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            n_q     <= n_d;
            sum_q   <= sum_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Handshake and write strobe decode straight from the state register.
    assign bus.inReady  = (state_q != WRITE);
    assign bus.pmWrEn   = (state_q == WRITE);
    assign bus.pmWrAddr = addr_q;
    assign bus.pmWrData = data_q;
    assign bus.cpuHold  = hold_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of frames plus hand sequences for the spec
// frame, timeout boundary and mid-frame resets; writes checked by scoreboard.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int L  = 8;
    localparam int W  = 13;
    localparam int TO = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_loader_if #(.AW(L), .DW(W)) ifc ();

    prog_loader #(
        .prog_mem_length (L),
        .prog_mem_width  (W),
        .HEADER          (8'hA5),
        .TIMEOUT         (TO)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (ifc)
    );

    typedef struct packed {
        logic [L-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    typedef struct {
        int n;
        bit bad_ck;
        bit junk;
        bit hdr_in_data;
        bit exp_done;
        bit exp_err;
        bit exp_hold;
    } vec_t;

    wr_t exp_q[$];
    int  n_cmp     = 0;
    int  n_bad     = 0;
    int  wr_count  = 0;
    int  stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input bit d, input bit e, input bit h);
        chk({tag, "_done"},    ifc.done,    d);
        chk({tag, "_error"},   ifc.error,   e);
        chk({tag, "_cpuHold"}, ifc.cpuHold, h);
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    task automatic check_write();
        wr_t e;
        wr_count++;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                     ifc.pmWrAddr, ifc.pmWrData);
        end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(ifc.pmWrAddr), 32'(e.addr));
            chk("wr_data", 32'(ifc.pmWrData), 32'(e.data));
        end
    endtask

    always @(negedge clk) begin
        if (ifc.pmWrEn === 1'b1) check_write();
    end

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        ifc.inData  = b;
        ifc.inValid = 1'b1;
        while (ifc.inReady !== 1'b1 && guard < 8) begin
            stall_cnt++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 8) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_wait: got inReady low for %0d cycles expected high", guard);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        ifc.inValid = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input int n, input bit bad_ck, input bit hdr_in_data);
        logic [7:0] sum, hi, lo, ck;
        int w0, s0;
        w0 = wr_count;
        s0 = stall_cnt;
        send_byte(8'hA5);
        send_byte(8'(n));
        sum = 8'(n);
        for (int i = 0; i <= n; i++) begin
            hi = 8'($urandom);
            lo = 8'($urandom);
            if (hdr_in_data && i == 0) lo = 8'hA5;
            if (hdr_in_data && i == 1) hi = 8'hA5;
            exp_q.push_back('{addr: L'(i), data: {hi[W-9:0], lo}});
            send_byte(hi);
            send_byte(lo);
            sum = sum + hi + lo;
        end
        ck = 8'(8'h00 - sum);
        if (bad_ck) ck = ck + 8'h01;
        send_byte(ck);
        ifc.inValid = 1'b0;
        chk("frame_writes", 32'(wr_count - w0), 32'(n + 1));
        chk("frame_stalls", 32'(stall_cnt - s0), 32'(n + 1));
        chk("frame_queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[7];
        logic [7:0] spec_bytes[7];
        int         w0;

        vecs[0] = '{n: 1,   bad_ck: 0, junk: 0, hdr_in_data: 0, exp_done: 1, exp_err: 0, exp_hold: 0};
        vecs[1] = '{n: 1,   bad_ck: 1, junk: 0, hdr_in_data: 0, exp_done: 0, exp_err: 1, exp_hold: 1};
        vecs[2] = '{n: 1,   bad_ck: 0, junk: 0, hdr_in_data: 0, exp_done: 1, exp_err: 0, exp_hold: 0};
        vecs[3] = '{n: 2,   bad_ck: 0, junk: 1, hdr_in_data: 0, exp_done: 1, exp_err: 0, exp_hold: 0};
        vecs[4] = '{n: 3,   bad_ck: 0, junk: 0, hdr_in_data: 1, exp_done: 1, exp_err: 0, exp_hold: 0};
        vecs[5] = '{n: 255, bad_ck: 0, junk: 0, hdr_in_data: 0, exp_done: 1, exp_err: 0, exp_hold: 0};
        vecs[6] = '{n: 0,   bad_ck: 1, junk: 0, hdr_in_data: 0, exp_done: 0, exp_err: 1, exp_hold: 1};

        ifc.inData  = 8'h00;
        ifc.inValid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk_flags("reset", 1'b0, 1'b0, 1'b1);
        chk("reset_pmWrEn",   ifc.pmWrEn,   1'b0);
        chk("reset_inReady",  ifc.inReady,  1'b1);
        chk("reset_pmWrAddr", 32'(ifc.pmWrAddr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reference frame from the datasheet
        spec_bytes = '{8'hA5, 8'h01, 8'h00, 8'h12, 8'h1F, 8'h34, 8'h9A};
        exp_q.push_back('{addr: 8'h00, data: 13'h0012});
        exp_q.push_back('{addr: 8'h01, data: 13'h1F34});
        w0 = wr_count;
        for (int i = 0; i < 7; i++) send_byte(spec_bytes[i]);
        ifc.inValid = 1'b0;
        chk("spec_writes", 32'(wr_count - w0), 32'd2);
        chk_flags("spec", 1'b1, 1'b0, 1'b0);
        $display("frame spec N=1: done=%0b error=%0b cpuHold=%0b", ifc.done, ifc.error, ifc.cpuHold);

        // Table of frames
        foreach (vecs[k]) begin
            if (vecs[k].junk) begin
                w0 = wr_count;
                send_byte(8'h00);
                send_byte(8'hFF);
                send_byte(8'h5A);
                ifc.inValid = 1'b0;
                chk("junk_no_write", 32'(wr_count - w0), 32'd0);
            end
            send_frame(vecs[k].n, vecs[k].bad_ck, vecs[k].hdr_in_data);
            chk_flags($sformatf("vec%0d", k), vecs[k].exp_done, vecs[k].exp_err, vecs[k].exp_hold);
            $display("frame vec%0d N=%0d bad_ck=%0b: done=%0b error=%0b cpuHold=%0b",
                     k, vecs[k].n, vecs[k].bad_ck, ifc.done, ifc.error, ifc.cpuHold);
        end

        // Stall of TIMEOUT cycles inside a frame: error, no write
        w0 = wr_count;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        idle(TO + 2);
        chk("timeout_no_write", 32'(wr_count - w0), 32'd0);
        chk_flags("timeout", 1'b0, 1'b1, 1'b1);
        $display("frame timeout stall=%0d: error=%0b cpuHold=%0b", TO, ifc.error, ifc.cpuHold);

        // Stall of TIMEOUT-1 cycles: frame still completes
        exp_q.push_back('{addr: 8'h00, data: 13'h0102});
        w0 = wr_count;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        idle(TO - 1);
        send_byte(8'h02);
        send_byte(8'hFD);
        ifc.inValid = 1'b0;
        chk("short_stall_writes", 32'(wr_count - w0), 32'd1);
        chk_flags("short_stall", 1'b1, 1'b0, 1'b0);
        $display("frame stall=%0d: done=%0b error=%0b", TO - 1, ifc.done, ifc.error);

        // Reset while waiting for the LO byte
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        ifc.inValid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_flags("rst_lo", 1'b0, 1'b0, 1'b1);
        chk("rst_lo_inReady", ifc.inReady, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(1, 1'b0, 1'b0);
        chk_flags("after_rst_lo", 1'b1, 1'b0, 1'b0);
        $display("frame after LO reset: done=%0b error=%0b", ifc.done, ifc.error);

        // Reset during the write cycle: strobe drops without a clock edge
        exp_q.push_back('{addr: 8'h00, data: 13'h0133});
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h33);
        ifc.inValid = 1'b0;
        #1;
        chk("write_in_flight", ifc.pmWrEn, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("pmWrEn_async_drop", ifc.pmWrEn, 1'b0);
        chk("rst_write_cpuHold", ifc.cpuHold, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(2, 1'b0, 1'b0);
        chk_flags("after_rst_write", 1'b1, 1'b0, 1'b0);
        $display("frame after WRITE reset: done=%0b error=%0b", ifc.done, ifc.error);

        idle(4);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
